wb_grf: RTL and testbench
=========================

WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 Parameter JAL_OFFSET, default 8: byte offset added to pcW to form the link value.
REQ-002 Parameter CNT_W, default 32: width of the writeback event counter.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 regWriteW  input  1  W-stage register-write enable.
REQ-006 memToRegW  input  1  select loadDataW as the writeback source.
REQ-007 jalOpW  input  1  select pcW+JAL_OFFSET as the writeback source; overrides memToRegW.
REQ-008 loadDataW  input  32  W-stage load data.
REQ-009 aluOutW  input  32  W-stage ALU result.
REQ-010 pcW  input  32  W-stage instruction PC.
REQ-011 writeRegW  input  5  W-stage destination register index.
REQ-012 rs1Addr, rs2Addr  input  5 each  D-stage read addresses.
REQ-013 rs1Data, rs2Data  output  32 each  combinational read data with W-stage bypass.
REQ-014 wbData  output  32  combinational selected writeback value.
REQ-015 dbgWe  output  1  registered: a register was written last cycle.
REQ-016 dbgAddr  output  5  registered: index written last cycle.
REQ-017 dbgData  output  32  registered: value written last cycle.
REQ-018 dbgPc  output  32  registered: pcW of the write last cycle.
REQ-019 wbCount  output  CNT_W  registered count of committed register writes.

Function
REQ-020 wbData SHALL be pcW+JAL_OFFSET (mod 2^32) if jalOpW, else loadDataW if memToRegW, else aluOutW.
REQ-021 Commit condition: regWriteW=1 and writeRegW!=0; only then SHALL reg[writeRegW] take wbData on the rising edge.
REQ-022 reg[0] SHALL read 0 at all times; writes targeting index 0 SHALL be discarded and SHALL not count.
REQ-023 rsNData SHALL be 0 if rsNAddr=0; else wbData if the commit condition holds and writeRegW=rsNAddr (same-cycle bypass); else reg[rsNAddr].
REQ-024 Both read ports SHALL bypass independently; rs1Addr=rs2Addr=writeRegW SHALL return wbData on both.
REQ-025 Each cycle the dbg* outputs SHALL register: dbgWe=commit condition, dbgAddr=writeRegW, dbgData=wbData, dbgPc=pcW; when dbgWe=0, dbgAddr/dbgData/dbgPc SHALL be 0.
REQ-026 wbCount SHALL increment by 1 on each committed write and wrap from 2^CNT_W-1 to 0.
REQ-027 Latency: a write is visible through reg[] on the cycle after the edge and through bypass in the same cycle; there is no stall or back-pressure.
REQ-028 X-free: with jalOpW=1, memToRegW SHALL have no effect on wbData.

Reset
REQ-029 Asserting reset SHALL immediately clear reg[1..31], dbgWe, dbgAddr, dbgData, dbgPc and wbCount to 0, independent of clk.
REQ-030 While reset is high no write SHALL commit and wbCount SHALL hold 0; rsNData SHALL be 0 except via bypass of the current inputs.
REQ-031 A reset asserted in the middle of a write cycle SHALL win: the register SHALL stay 0 after the edge.
REQ-032 The first commit SHALL take effect on the first rising edge after reset deasserts.

Verification
REQ-033 Write: regWriteW=1, writeRegW=5, aluOutW=0x12345678, edge; then rs1Addr=5 -> rs1Data=0x12345678, wbCount=1, dbgWe=1, dbgAddr=5.
REQ-034 Zero register: regWriteW=1, writeRegW=0, aluOutW=0xFFFFFFFF; rs2Addr=0 -> rs2Data=0 before and after the edge, wbCount unchanged, dbgWe=0.
REQ-035 Bypass: reg[7]=1, then same cycle regWriteW=1, writeRegW=7, memToRegW=1, loadDataW=0xA5A5A5A5, rs1Addr=rs2Addr=7 -> both read 0xA5A5A5A5 before the edge.
REQ-036 Link: jalOpW=1, memToRegW=1, pcW=0x00003000, writeRegW=31, edge -> reg[31]=0x00003008, dbgPc=0x00003000.
REQ-037 Async reset: after several writes, pulse reset between edges -> all reads 0 and wbCount=0 immediately, with no clk edge needed.
REQ-038 Wrap: with CNT_W=4, 16 commits -> wbCount returns to 0.

Source files
------------

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - writeback-stage general register file with bypass, debug trace and commit counter
//
// Purpose: 31 x 32-bit general registers (x0 hardwired to zero) written from
// the W stage, two combinational read ports for the D stage with same-cycle
// W-stage bypass, a registered one-cycle trace of the last committed write,
// and a wrapping count of committed writes.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   regWriteW             W-stage write enable
//   memToRegW, jalOpW     writeback source select (jalOpW has priority)
//   loadDataW, aluOutW    candidate writeback values
//   pcW                   W-stage PC (link value base, traced in dbgPc)
//   writeRegW             destination index
//   rs1Addr, rs2Addr      read addresses
//   rs1Data, rs2Data      read data (bypassed)
//   wbData                selected writeback value
//   dbgWe/dbgAddr/dbgData/dbgPc  registered trace of last cycle's commit
//   wbCount               committed-write counter (CNT_W bits, wraps)

module wb_grf #(
  parameter int JAL_OFFSET = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regWriteW,
  input  logic             memToRegW,
  input  logic             jalOpW,
  input  logic [31:0]      loadDataW,
  input  logic [31:0]      aluOutW,
  input  logic [31:0]      pcW,
  input  logic [4:0]       writeRegW,
  input  logic [4:0]       rs1Addr,
  input  logic [4:0]       rs2Addr,
  output logic [31:0]      rs1Data,
  output logic [31:0]      rs2Data,
  output logic [31:0]      wbData,
  output logic             dbgWe,
  output logic [4:0]       dbgAddr,
  output logic [31:0]      dbgData,
  output logic [31:0]      dbgPc,
  output logic [CNT_W-1:0] wbCount
);

  logic [31:0]      r_regs [1:31];
  logic             r_dbg_we;
  logic [4:0]       r_dbg_addr;
  logic [31:0]      r_dbg_data;
  logic [31:0]      r_dbg_pc;
  logic [CNT_W-1:0] r_wb_count;

  logic [31:0]      w_wb_data;
  logic             w_commit;
  logic [31:0]      w_rs1_data;
  logic [31:0]      w_rs2_data;

  // jalOpW is tested first so memToRegW can never leak into a link value
  always_comb begin
    w_wb_data = aluOutW;
    if (jalOpW) begin
      w_wb_data = pcW + 32'(JAL_OFFSET);
    end else if (memToRegW) begin
      w_wb_data = loadDataW;
    end
  end

  assign w_commit = regWriteW && (writeRegW != 5'd0);

  // Bypass is not gated by reset: the current inputs stay visible even while
  // the array itself is held clear.
  always_comb begin
    w_rs1_data = '0;
    if (rs1Addr != 5'd0) begin
      if (w_commit && (writeRegW == rs1Addr)) begin
        w_rs1_data = w_wb_data;
      end else begin
        w_rs1_data = r_regs[rs1Addr];
      end
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (rs2Addr != 5'd0) begin
      if (w_commit && (writeRegW == rs2Addr)) begin
        w_rs2_data = w_wb_data;
      end else begin
        w_rs2_data = r_regs[rs2Addr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[writeRegW] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg_we   <= 1'b0;
      r_dbg_addr <= '0;
      r_dbg_data <= '0;
      r_dbg_pc   <= '0;
      r_wb_count <= '0;
    end else begin
      r_dbg_we   <= w_commit;
      r_dbg_addr <= w_commit ? writeRegW : 5'd0;
      r_dbg_data <= w_commit ? w_wb_data : 32'd0;
      r_dbg_pc   <= w_commit ? pcW : 32'd0;
      if (w_commit) begin
        r_wb_count <= r_wb_count + CNT_W'(1);
      end
    end
  end

  assign wbData  = w_wb_data;
  assign rs1Data = w_rs1_data;
  assign rs2Data = w_rs2_data;
  assign dbgWe   = r_dbg_we;
  assign dbgAddr = r_dbg_addr;
  assign dbgData = r_dbg_data;
  assign dbgPc   = r_dbg_pc;
  assign wbCount = r_wb_count;

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - self-checking bench for wb_grf against an array-based reference model

module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic        regWriteW, memToRegW, jalOpW;
  logic [31:0] loadDataW, aluOutW, pcW;
  logic [4:0]  writeRegW, rs1Addr, rs2Addr;

  logic [31:0] rs1Data, rs2Data, wbData, dbgData, dbgPc;
  logic        dbgWe;
  logic [4:0]  dbgAddr;
  logic [31:0] wbCount;

  logic [31:0] rs1Data4, rs2Data4, wbData4, dbgData4, dbgPc4;
  logic        dbgWe4;
  logic [4:0]  dbgAddr4;
  logic [3:0]  wbCount4;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_regs [32];
  int          m_count;
  logic        m_dbg_we;
  logic [4:0]  m_dbg_addr;
  logic [31:0] m_dbg_data, m_dbg_pc;

  wb_grf #(.JAL_OFFSET(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .regWriteW(regWriteW), .memToRegW(memToRegW),
    .jalOpW(jalOpW), .loadDataW(loadDataW), .aluOutW(aluOutW), .pcW(pcW),
    .writeRegW(writeRegW), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .wbData(wbData), .dbgWe(dbgWe),
    .dbgAddr(dbgAddr), .dbgData(dbgData), .dbgPc(dbgPc), .wbCount(wbCount)
  );

  wb_grf #(.JAL_OFFSET(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .regWriteW(regWriteW), .memToRegW(memToRegW),
    .jalOpW(jalOpW), .loadDataW(loadDataW), .aluOutW(aluOutW), .pcW(pcW),
    .writeRegW(writeRegW), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data4), .rs2Data(rs2Data4), .wbData(wbData4), .dbgWe(dbgWe4),
    .dbgAddr(dbgAddr4), .dbgData(dbgData4), .dbgPc(dbgPc4), .wbCount(wbCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_wb();
    if (jalOpW)    return pcW + 32'd8;
    if (memToRegW) return loadDataW;
    return aluOutW;
  endfunction

  function automatic logic m_commit();
    return regWriteW && (writeRegW != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_commit() && writeRegW == a) return m_wb();
    return m_regs[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count    = 0;
    m_dbg_we   = 1'b0;
    m_dbg_addr = 5'd0;
    m_dbg_data = 32'd0;
    m_dbg_pc   = 32'd0;
  endtask

  task automatic set_in(input logic we, input logic mem, input logic jal,
                        input logic [31:0] ld, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
    regWriteW = we; memToRegW = mem; jalOpW = jal;
    loadDataW = ld; aluOutW = alu; pcW = pc;
    writeRegW = wr; rs1Addr = a1; rs2Addr = a2;
  endtask

  // One clock: combinational checks at the falling edge, model update at the
  // rising edge, registered checks 1 time unit later.
  task automatic cycle();
    logic [31:0] wb;
    logic        c;
    logic [4:0]  wr;
    logic [31:0] pc;
    @(negedge clk);
    if (reset) clear_model();
    wb = m_wb(); c = m_commit(); wr = writeRegW; pc = pcW;
    chk("wbData", wbData, wb);
    chk("rs1Data", rs1Data, m_read(rs1Addr));
    chk("rs2Data", rs2Data, m_read(rs2Addr));
    chk("rs1Data_cnt4", rs1Data4, m_read(rs1Addr));
    @(posedge clk);
    if (reset) begin
      clear_model();
    end else begin
      if (c) begin
        m_regs[wr] = wb;
        m_count++;
      end
      m_dbg_we   = c;
      m_dbg_addr = c ? wr : 5'd0;
      m_dbg_data = c ? wb : 32'd0;
      m_dbg_pc   = c ? pc : 32'd0;
    end
    #1;
    chk("dbgWe", dbgWe, m_dbg_we);
    chk("dbgAddr", dbgAddr, m_dbg_addr);
    chk("dbgData", dbgData, m_dbg_data);
    chk("dbgPc", dbgPc, m_dbg_pc);
    chk("wbCount", wbCount, m_count);
    chk("wbCount4", wbCount4, m_count % 16);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
    clear_model();
    @(posedge clk); #1;
    chk("rst_dbgWe", dbgWe, 1'b0);
    chk("rst_wbCount", wbCount, 32'd0);
    chk("rst_rs1", rs1Data, 32'd0);
    reset = 1'b0;

    // basic write then read-back
    set_in(1, 0, 0, 32'd0, 32'h12345678, 32'h100, 5'd5, 5'd0, 5'd0);
    cycle();
    chk("w_count1", wbCount, 32'd1);
    chk("w_dbgAddr5", dbgAddr, 32'd5);
    chk("w_dbgWe1", dbgWe, 1'b1);
    set_in(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("w_rs1_readback", rs1Data, 32'h12345678);
    cycle();

    // x0 write discarded
    set_in(1, 0, 0, 32'd0, 32'hFFFFFFFF, 32'h104, 5'd0, 5'd0, 5'd0);
    #1;
    chk("z_rs2_before", rs2Data, 32'd0);
    cycle();
    chk("z_dbgWe", dbgWe, 1'b0);
    chk("z_count", wbCount, 32'd1);
    chk("z_rs2_after", rs2Data, 32'd0);

    // dual-port same-cycle bypass
    set_in(1, 0, 0, 32'd0, 32'd1, 32'h108, 5'd7, 5'd0, 5'd0);
    cycle();
    set_in(1, 1, 0, 32'hA5A5A5A5, 32'd0, 32'h10C, 5'd7, 5'd7, 5'd7);
    #1;
    chk("byp_rs1", rs1Data, 32'hA5A5A5A5);
    chk("byp_rs2", rs2Data, 32'hA5A5A5A5);
    cycle();

    // link write, memToRegW ignored
    set_in(1, 1, 1, 32'hDEADBEEF, 32'h55555555, 32'h00003000, 5'd31, 5'd0, 5'd0);
    cycle();
    chk("jal_dbgPc", dbgPc, 32'h00003000);
    chk("jal_dbgData", dbgData, 32'h00003008);
    set_in(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd7);
    #1;
    chk("jal_reg31", rs1Data, 32'h00003008);

    // asynchronous reset between edges
    set_in(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    reset = 1'b1;
    #1;
    chk("ar_rs1", rs1Data, 32'd0);
    chk("ar_rs2", rs2Data, 32'd0);
    chk("ar_wbCount", wbCount, 32'd0);
    chk("ar_wbCount4", wbCount4, 4'd0);
    chk("ar_dbgWe", dbgWe, 1'b0);
    clear_model();
    reset = 1'b0;
    cycle();

    // reset held across a write edge wins
    set_in(1, 0, 0, 32'd0, 32'hCAFEBABE, 32'h200, 5'd9, 5'd0, 5'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_in(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd0);
    #1;
    chk("rw_reg9", rs1Data, 32'd0);

    // 16 commits from zero: first edge after reset commits, 4-bit counter wraps
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom, $urandom,
             5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
      cycle();
    end
    chk("wrap_cnt4", wbCount4, 4'd0);
    chk("wrap_cnt32", wbCount, 32'd16);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr;
      wr = 5'($urandom);
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 4) == 0),
             $urandom, $urandom, $urandom, wr,
             ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
             ($urandom_range(0, 2) == 0) ? wr : 5'($urandom));
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
